// File: rtl/jt12_sh_ram_if.sv
// Purpose: bundle of the data/control signals of jt12_sh_ram.
//   master: drives clk_en, flush, din; observes drop, ready, slot, wrap.
//   slave : the delay line itself.
// Ports (signals):
//   clk_en - stage advance enable
//   flush  - synchronous re-initialise request
//   din    - word written into the current slot
//   drop   - registered delayed word
//   ready  - high once the init sweep is done
//   slot   - current read/write slot index
//   wrap   - one-clk pulse when slot wraps to 0
interface jt12_sh_ram_if #(
  parameter int unsigned width  = 5,
  parameter int unsigned stages = 32
);
  localparam int unsigned SlotW = ($clog2(stages - 1) > 1) ? $clog2(stages - 1) : 1;

  logic             clk_en;
  logic             flush;
  logic [width-1:0] din;
  logic [width-1:0] drop;
  logic             ready;
  logic [SlotW-1:0] slot;
  logic             wrap;

  modport master (
    output clk_en, flush, din,
    input  drop, ready, slot, wrap
  );

  modport slave (
    input  clk_en, flush, din,
    output drop, ready, slot, wrap
  );
endinterface

// File: rtl/jt12_sh_ram.sv
// Purpose: RAM-based fixed delay line. A word written at enabled edge E is
//   presented on drop after enabled edge E+stages-1, using a circular buffer
//   of stages-1 entries plus the registered output. After reset or flush every
//   slot is swept to rstval before ready rises.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - jt12_sh_ram_if slave: clk_en, flush, din in; drop, ready, slot, wrap out
module jt12_sh_ram #(
  parameter int unsigned      width  = 5,
  parameter int unsigned      stages = 32,
  parameter logic [width-1:0] rstval = '0
) (
  input logic          clk,
  input logic          rst_n,
  jt12_sh_ram_if.slave bus
);

  localparam int unsigned      SlotW    = ($clog2(stages - 1) > 1) ? $clog2(stages - 1) : 1;
  localparam int unsigned      Depth    = stages - 1;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(stages - 2);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           r_state, w_state_d;
  logic [SlotW-1:0] r_ptr, w_ptr_d;
  logic [width-1:0] r_drop, w_drop_d;
  logic             r_ready, w_ready_d;
  logic             r_wrap, w_wrap_d;
  logic             w_mem_we;
  logic [width-1:0] w_mem_wdata;

  // No reset on the array so it can map onto block RAM.
  logic [width-1:0] r_mem [Depth];

  always_comb begin
    w_state_d   = r_state;
    w_ptr_d     = r_ptr;
    w_drop_d    = r_drop;
    w_ready_d   = r_ready;
    w_wrap_d    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wdata = bus.din;

    if (bus.flush) begin
      // Flush beats clk_en; din on this edge is dropped.
      w_state_d = StInit;
      w_ptr_d   = '0;
      w_ready_d = 1'b0;
      w_drop_d  = rstval;
    end else begin
      case (r_state)
        StInit: begin
          // Sweep runs on every clk edge regardless of clk_en.
          w_mem_we    = 1'b1;
          w_mem_wdata = rstval;
          w_drop_d    = rstval;
          if (r_ptr == LastSlot) begin
            w_ptr_d   = '0;
            w_state_d = StRun;
            w_ready_d = 1'b1;
          end else begin
            w_ptr_d = r_ptr + SlotW'(1);
          end
        end
        StRun: begin
          if (bus.clk_en) begin
            // Read-before-write on the same slot gives the full rotation delay.
            w_drop_d = r_mem[r_ptr];
            w_mem_we = 1'b1;
            if (r_ptr == LastSlot) begin
              w_ptr_d  = '0;
              w_wrap_d = 1'b1;
            end else begin
              w_ptr_d = r_ptr + SlotW'(1);
            end
          end
        end
        default: begin
          w_state_d = StInit;
          w_ptr_d   = '0;
          w_ready_d = 1'b0;
          w_drop_d  = rstval;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StInit;
      r_ptr   <= '0;
      r_drop  <= rstval;
      r_ready <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_drop  <= w_drop_d;
      r_ready <= w_ready_d;
      r_wrap  <= w_wrap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_ptr] <= w_mem_wdata;
    end
  end

  assign bus.drop  = r_drop;
  assign bus.ready = r_ready;
  assign bus.slot  = r_ptr;
  assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_jt12_sh_ram.sv
// Directed and randomised checks of jt12_sh_ram on three parameter sets:
//   A: width=5,  stages=4,  rstval=0
//   B: width=1,  stages=3,  rstval=1
//   C: width=16, stages=32, rstval=16'hFFFF
module tb_jt12_sh_ram;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jt12_sh_ram_if #(.width(5),  .stages(4))  ifa ();
  jt12_sh_ram_if #(.width(1),  .stages(3))  ifb ();
  jt12_sh_ram_if #(.width(16), .stages(32)) ifc ();

  jt12_sh_ram #(.width(5), .stages(4), .rstval(5'h00)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  jt12_sh_ram #(.width(1), .stages(3), .rstval(1'b1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  jt12_sh_ram #(.width(16), .stages(32), .rstval(16'hFFFF)) u_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Flip-flop shift-register references: stages-1 taps feeding an output register.
  logic [0:0]  sr_b [2];
  logic [15:0] sr_c [31];
  logic [0:0]  exp_b;
  logic [15:0] exp_c;
  logic        en_b, en_c, en;
  logic [0:0]  db;
  logic [15:0] dc;
  int          e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ifa.clk_en = 1'b0; ifa.flush = 1'b0; ifa.din = '0;
    ifb.clk_en = 1'b0; ifb.flush = 1'b0; ifb.din = '0;
    ifc.clk_en = 1'b0; ifc.flush = 1'b0; ifc.din = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ifa.ready), 32'd0);
    chk("rst_drop",  32'(ifa.drop),  32'd0);
    chk("rst_slot",  32'(ifa.slot),  32'd0);
    chk("rst_wrap",  32'(ifa.wrap),  32'd0);
    chk("rst_drop_b", 32'(ifb.drop), 32'd1);
    chk("rst_drop_c", 32'(ifc.drop), 32'hFFFF);
    rst_n = 1'b1;

    // Init sweep: ready after exactly 3 edges, clk_en low
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("init_ready", 32'(ifa.ready), 32'(i == 3));
      chk("init_slot",  32'(ifa.slot),  i % 3);
      chk("init_drop",  32'(ifa.drop),  32'd0);
    end
    tick();
    chk("idle_ready", 32'(ifa.ready), 32'd1);
    chk("idle_slot",  32'(ifa.slot),  32'd0);
    chk("idle_wrap",  32'(ifa.wrap),  32'd0);

    // Latency: din=1..9 on every edge, drop lags by 3 enabled edges
    ifa.clk_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      ifa.din = 5'(k);
      tick();
      chk("lat_drop", 32'(ifa.drop), (k >= 4) ? k - 3 : 0);
      chk("lat_slot", 32'(ifa.slot), k % 3);
      chk("lat_wrap", 32'(ifa.wrap), 32'(k % 3 == 0));
    end

    // Flush with clk_en high and din=1F; slots hold 7,8,9 beforehand
    ifa.flush = 1'b1;
    ifa.din   = 5'h1F;
    tick();
    chk("fl_ready", 32'(ifa.ready), 32'd0);
    chk("fl_drop",  32'(ifa.drop),  32'd0);
    chk("fl_slot",  32'(ifa.slot),  32'd0);
    chk("fl_wrap",  32'(ifa.wrap),  32'd0);
    ifa.flush  = 1'b0;
    ifa.clk_en = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("fl_init_ready", 32'(ifa.ready), 32'(i == 3));
      chk("fl_init_drop",  32'(ifa.drop),  32'd0);
    end
    ifa.clk_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      ifa.din = 5'(20 + k);
      tick();
      chk("fl_new_drop", 32'(ifa.drop), (k == 4) ? 32'd21 : 32'd0);
    end

    // Enable gating: clk_en every 3rd clk, values must hold in between
    ifa.flush = 1'b1;
    tick();
    ifa.flush  = 1'b0;
    ifa.clk_en = 1'b0;
    repeat (3) tick();
    chk("gate_start_ready", 32'(ifa.ready), 32'd1);
    e = 0;
    for (int j = 1; j <= 18; j++) begin
      en = (j % 3 == 0);
      ifa.clk_en = en;
      if (en) ifa.din = 5'(e + 1);
      tick();
      if (en) e++;
      chk("gate_drop", 32'(ifa.drop), (e >= 4) ? e - 3 : 0);
      chk("gate_slot", 32'(ifa.slot), e % 3);
      chk("gate_wrap", 32'(ifa.wrap), 32'(en && (e % 3 == 0)));
    end

    // Async reset mid-RUN (drop is 3 here), no clk edge involved
    ifa.clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_run_drop",  32'(ifa.drop),  32'd0);
    chk("ar_run_ready", 32'(ifa.ready), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar_init_slot1", 32'(ifa.slot), 32'd1);
    // Async reset mid-INIT
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_init_slot",  32'(ifa.slot),  32'd0);
    chk("ar_init_ready", 32'(ifa.ready), 32'd0);
    chk("ar_init_drop",  32'(ifa.drop),  32'd0);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("ar_sweep_ready", 32'(ifa.ready), 32'(i == 3));
      chk("ar_sweep_slot",  32'(ifa.slot),  i % 3);
    end

    // Parameter sweep: wait (bounded) for the 31-edge sweep of C
    for (int i = 0; i < 40 && !ifc.ready; i++) begin
      chk("sw_c_init_drop", 32'(ifc.drop), 32'hFFFF);
      chk("sw_b_init_drop", 32'(ifb.drop), 32'd1);
      tick();
    end
    chk("sw_c_ready", 32'(ifc.ready), 32'd1);
    chk("sw_b_ready", 32'(ifb.ready), 32'd1);

    foreach (sr_b[i]) sr_b[i] = 1'b1;
    foreach (sr_c[i]) sr_c[i] = 16'hFFFF;
    exp_b = 1'b1;
    exp_c = 16'hFFFF;
    for (int n = 0; n < 400; n++) begin
      en_b = 1'($urandom_range(0, 1));
      en_c = 1'($urandom_range(0, 1));
      db   = 1'($urandom);
      dc   = 16'($urandom);
      ifb.clk_en = en_b;
      ifb.din    = db;
      ifc.clk_en = en_c;
      ifc.din    = dc;
      tick();
      if (en_b) begin
        exp_b   = sr_b[1];
        sr_b[1] = sr_b[0];
        sr_b[0] = db;
      end
      if (en_c) begin
        exp_c = sr_c[30];
        for (int i = 30; i > 0; i--) sr_c[i] = sr_c[i-1];
        sr_c[0] = dc;
      end
      chk("sw_b_drop", 32'(ifb.drop), 32'(exp_b));
      chk("sw_c_drop", 32'(ifc.drop), 32'(exp_c));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
